// File: rtl/usb_uart_tx_arbiter_if.sv
// Byte-pipe bundle between the on-chip sources, the arbiter and the usb_uart
// host-bound input. The master side is the arbiter; the slave side is the
// surrounding fabric (sources plus usb_uart).
interface usb_uart_tx_arbiter_if #(
    parameter int NUM_SRC = 4
);
    logic [8*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   src_valid;
    logic [NUM_SRC-1:0]   src_ready;
    logic [7:0]           uart_in_data;
    logic                 uart_in_valid;
    logic                 uart_in_ready;

    modport master (
        input  src_data,
        input  src_valid,
        input  uart_in_ready,
        output src_ready,
        output uart_in_data,
        output uart_in_valid
    );

    modport slave (
        output src_data,
        output src_valid,
        output uart_in_ready,
        input  src_ready,
        input  uart_in_data,
        input  uart_in_valid
    );
endinterface

// File: rtl/usb_uart_tx_arbiter.sv
// Round-robin arbiter sharing the usb_uart host-bound byte pipe among several
// byte sources. A grant lasts one message (EOL byte, burst limit or idle
// timeout) so that lines from different sources never interleave.
module usb_uart_tx_arbiter #(
    parameter int          NUM_SRC      = 4,
    parameter int          MAX_BURST    = 64,
    parameter int          IDLE_TIMEOUT = 4800,
    parameter logic [7:0]  EOL_BYTE     = 8'h0A
) (
    input  logic                    clk_48mhz,
    input  logic                    reset,
    usb_uart_tx_arbiter_if.master   bus,
    output logic [NUM_SRC-1:0]      grant,
    output logic                    busy
);

    localparam int PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
    localparam logic [IDLE_W-1:0]  IDLE_LIMIT  = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [PTR_W-1:0]   LAST_SRC    = PTR_W'(NUM_SRC - 1);
    localparam logic [PTR_W:0]     NUM_SRC_W   = (PTR_W + 1)'(NUM_SRC);

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;

    logic [PTR_W-1:0]     g_idx;
    logic [7:0]           g_data;
    logic                 g_valid;
    logic                 xfer;
    logic                 release_now;
    logic                 found;
    logic [PTR_W-1:0]     pick;
    logic [PTR_W:0]       cand;

    // Decode the one-hot owner into an index plus its data/valid.
    always_comb begin
        g_idx   = '0;
        g_data  = 8'h00;
        g_valid = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant_q[k]) begin
                g_idx   = PTR_W'(k);
                g_data  = bus.src_data[8*k +: 8];
                g_valid = bus.src_valid[k];
            end
        end
    end

    // Zero-latency mux from the owner to usb_uart; everything quiet in ARB.
    always_comb begin
        bus.uart_in_data  = 8'h00;
        bus.uart_in_valid = 1'b0;
        bus.src_ready     = '0;
        if (state_q == HOLD) begin
            bus.uart_in_data  = g_data;
            bus.uart_in_valid = g_valid;
            bus.src_ready     = grant_q & {NUM_SRC{bus.uart_in_ready}};
        end
    end

    assign xfer = bus.uart_in_valid && bus.uart_in_ready;

    // Next-state: round-robin pick in ARB, message tracking and release in HOLD.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        release_now = 1'b0;
        found       = 1'b0;
        pick        = '0;
        cand        = '0;

        case (state_q)
            ARB: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(i);
                    if (cand >= NUM_SRC_W) begin
                        cand = cand - NUM_SRC_W;
                    end
                    if (!found && bus.src_valid[cand[PTR_W-1:0]]) begin
                        found = 1'b1;
                        pick  = cand[PTR_W-1:0];
                    end
                end
                if (found) begin
                    for (int k = 0; k < NUM_SRC; k++) begin
                        grant_d[k] = (pick == PTR_W'(k));
                    end
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                    state_d     = HOLD;
                end
            end

            HOLD: begin
                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + BURST_W'(1);
                end
                if (g_valid) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end

                release_now = (xfer && (g_data == EOL_BYTE)) ||
                              (xfer && (burst_cnt_d == BURST_LIMIT)) ||
                              (!g_valid && (idle_cnt_d == IDLE_LIMIT));

                if (release_now) begin
                    state_d     = ARB;
                    grant_d     = '0;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                    rr_ptr_d    = (g_idx == LAST_SRC) ? '0 : g_idx + PTR_W'(1);
                end
            end

            default: begin
                state_d = ARB;
                grant_d = '0;
            end
        endcase
    end

    assign busy_d = (state_d == HOLD);

    // State and arbitration registers; reset drops any grant immediately.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state_q     <= ARB;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: doc/usb_uart_tx_arbiter.md
# usb_uart_tx_arbiter

Round-robin arbiter that shares the single host-bound byte pipe of `usb_uart` (`uart_in_data/valid/ready`) among several on-chip byte sources. A grant is held for one "message", ending at an end-of-line byte, a burst limit or an idle timeout, so output lines from different sources never interleave on the host terminal. Sits between the debug and console producers and the `usb_uart` instance, in the `clk_48mhz` domain.

## Interface
Parameters:
- `NUM_SRC`, 4, number of requesters (2..8)
- `MAX_BURST`, 64, maximum bytes accepted per grant (≥1)
- `IDLE_TIMEOUT`, 4800, consecutive cycles with the granted source's valid low before release (100 µs at 48 MHz, ≥1)
- `EOL_BYTE`, 8'h0A, byte that ends a message

Ports:
- `clk_48mhz` in 1: sole clock
- `reset` in 1: asynchronous, active-high
- `src_data` in 8*NUM_SRC: source k drives bits [8k+7:8k]
- `src_valid` in NUM_SRC: per-source byte valid
- `src_ready` out NUM_SRC: per-source byte accepted
- `uart_in_data` out 8: to `usb_uart` `uart_in_data`
- `uart_in_valid` out 1: to `usb_uart` `uart_in_valid`
- `uart_in_ready` in 1: from `usb_uart` `uart_in_ready`
- `grant` out NUM_SRC: one-hot current owner, all-zero when idle (registered)
- `busy` out 1: high while any grant is held (registered)

## Operation
- States: ARB and HOLD. Registers: `grant`, `rr_ptr` (index of highest-priority source), `burst_cnt` (clog2(MAX_BURST+1) bits), `idle_cnt` (clog2(IDLE_TIMEOUT+1) bits).
- ARB: if any `src_valid` is high, pick the first requester at or after `rr_ptr`, wrapping modulo NUM_SRC. Set `grant`, clear both counters and go to HOLD. Otherwise stay in ARB.
- HOLD, datapath (combinational from registered `grant`): `uart_in_data = src_data[g]`, `uart_in_valid = src_valid[g]`, `src_ready[g] = uart_in_ready`. Every other `src_ready` is 0.
- ARB datapath: `uart_in_valid=0`, `uart_in_data=8'h00`, all `src_ready=0`.
- Transfer: the cycle in which `uart_in_valid && uart_in_ready` are both high. On each transfer, `burst_cnt` increments and `idle_cnt` clears.
- Idle counting: `idle_cnt` increments on each HOLD cycle with `src_valid[g]` low. A cycle with valid high clears it, even if `uart_in_ready` is low. A host stall never triggers release.
- Release: leave HOLD at the clock edge ending any of these cycles:
  - a transfer whose byte equals EOL_BYTE;
  - a transfer that brings `burst_cnt` to MAX_BURST;
  - a cycle in which `idle_cnt` reaches IDLE_TIMEOUT.
- On release: `grant` clears, the state returns to ARB, and `rr_ptr` becomes (g+1) mod NUM_SRC.
- Simultaneous release conditions (for example EOL on the MAX_BURST-th byte) cause a single release.
- Bytes are never dropped or duplicated. Per-source order is preserved.

## Timing
- Reset (async assert, sync-released use): state ARB, `grant=0`, `busy=0`, `rr_ptr=0`, counters 0. Outputs during reset: `uart_in_valid=0`, `uart_in_data=0`, `src_ready=0`.
- Reset asserted mid-message drops the grant immediately. Any partial message is the source's responsibility.
- Arbitration latency: valid is first seen in ARB at cycle t; `grant`/`busy` go high at t+1; the first transfer can occur at t+1.
- Gap after release: one ARB cycle minimum, then the next grant. A back-to-back re-grant to the same source is allowed only if no other source is requesting.
- Holding a message of N bytes with the host always ready: N consecutive transfers, one per cycle.
- `grant`, `busy`, and the state are registered. The data/valid/ready paths are purely combinational through the mux (zero latency).
- A source that deasserts valid without EOL loses the grant exactly IDLE_TIMEOUT cycles after its last valid-high cycle.

## Test plan
- Single source 2 sends "AB\n" (41,42,0A) with ready always high. Required: `grant=4'b0100` one cycle after valid, three consecutive transfers, release after 0x0A, `busy` low the next cycle.
- Sources 0 and 3 both send 3-byte lines starting in the same cycle, after reset. Required: source 0's full line first, then a 1-cycle ARB gap, then source 3's line. No interleave.
- With MAX_BURST=4, source 1 streams 10 non-EOL bytes while source 0 also requests. Required: source 1 is released after 4 transfers, source 0 is granted next, and source 1 is regranted later (rr_ptr wrap).
- With IDLE_TIMEOUT=8, source 0 sends 1 byte and then holds valid low. Required: release exactly 8 cycles after the last valid-high cycle. Also hold `uart_in_ready` low 20 cycles with valid high: no release, and no `src_ready` pulse.
- EOL byte sent as the MAX_BURST-th byte. Required: a single release and `rr_ptr` advancing by exactly one.
- Assert `reset` mid-line while `uart_in_ready` is high. Required: in the same cycle, `grant=0`, `uart_in_valid=0` and `src_ready=0` asynchronously; after deassert, arbitration restarts at source 0.
